// File: rtl/replication_decoder_pkg.sv
// Shared frame layout, status codes and FIFO entry type for the replication decoder.
package replication_decoder_pkg;

  localparam int FRAME_W = 7;
  localparam int PAY_W   = 3;

  localparam int PAD_BIT = 6;
  localparam int A_BIT   = 5;
  localparam int REP_HI  = 4;
  localparam int REP_LO  = 1;
  localparam int C_BIT   = 0;

  typedef enum logic [1:0] {
    ST_CLEAN = 2'b00,
    ST_CORR  = 2'b01,
    ST_TIE   = 2'b10,
    ST_PAD   = 2'b11
  } status_t;

  typedef struct packed {
    logic [PAY_W-1:0] data;
    status_t          status;
  } entry_t;

endpackage

// File: rtl/replication_vote.sv
// Combinational majority vote over the four replicated b0 copies.
module replication_vote
  import replication_decoder_pkg::*;
(
  input  logic [3:0] copies,
  output logic       b0,
  output status_t    status
);

  logic [2:0] ones;

  // NOTE: every signal written here gets a default first so no latch can be inferred.
  always_comb begin
    ones   = 3'(copies[0]) + 3'(copies[1]) + 3'(copies[2]) + 3'(copies[3]);
    b0     = 1'b0;
    status = ST_CLEAN;
    case (ones)
      3'd4:    begin b0 = 1'b1; status = ST_CLEAN; end
      3'd3:    begin b0 = 1'b1; status = ST_CORR;  end
      3'd2:    begin b0 = 1'b0; status = ST_TIE;   end
      3'd1:    begin b0 = 1'b0; status = ST_CORR;  end
      default: begin b0 = 1'b0; status = ST_CLEAN; end
    endcase
  end

endmodule

// File: rtl/replication_decoder.sv
// Replication-code frame decoder: vote, pad check, output FIFO and saturating error counters.
module replication_decoder
  import replication_decoder_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FRAME_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PAY_W-1:0]   out_data,
  output logic [1:0]         out_status,
  input  logic               clr_cnt,
  output logic [CNT_W-1:0]   corr_cnt,
  output logic [CNT_W-1:0]   uncorr_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          vote_b0;
  status_t       vote_status;
  entry_t        dec;
  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  replication_vote u_vote (
    .copies (in_data[REP_HI:REP_LO]),
    .b0     (vote_b0),
    .status (vote_status)
  );

  // Pad error overrides the vote status but the payload is still decoded.
  always_comb begin
    dec.data   = {in_data[A_BIT], vote_b0, in_data[C_BIT]};
    dec.status = in_data[PAD_BIT] ? ST_PAD : vote_status;
  end

  assign in_ready  = (count < (AW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Outputs read zero when empty so no stale or unreset storage is visible.
  assign out_data   = out_valid ? mem[rd_ptr].data   : '0;
  assign out_status = out_valid ? mem[rd_ptr].status : ST_CLEAN;

  // NOTE: storage is not reset; occupancy is tracked by count and the output is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Clear wins over a coincident increment; both counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (clr_cnt) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (push) begin
      if (dec.status == ST_CORR && corr_cnt != '1)
        corr_cnt <= corr_cnt + 1'b1;
      if ((dec.status == ST_TIE || dec.status == ST_PAD) && uncorr_cnt != '1)
        uncorr_cnt <= uncorr_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_replication_decoder.sv
// Directed + sweep bench for replication_decoder with a scoreboard queue and counter model.
module tb_replication_decoder;

  typedef struct packed {
    logic [2:0] data;
    logic [1:0] status;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_data;
  logic [1:0] out_status;
  logic       clr_cnt;
  logic [1:0] corr_cnt;
  logic [1:0] uncorr_cnt;

  exp_t       sb [$];
  int         exp_corr;
  int         exp_uncorr;
  int         errors = 0;
  int         checks = 0;
  bit         last_accept = 1'b0;

  replication_decoder #(.DEPTH(2), .CNT_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_status (out_status),
    .clr_cnt    (clr_cnt),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t decode(input logic [6:0] f);
    exp_t e;
    int   n;
    n = $countones(f[4:1]);
    e.data = {f[5], (n >= 3), f[0]};
    if (f[6])                  e.status = 2'b11;
    else if (n == 2)           e.status = 2'b10;
    else if (n == 1 || n == 3) e.status = 2'b01;
    else                       e.status = 2'b00;
    return e;
  endfunction

  // One clock: compare/pop the head, push the accepted frame, then check counters after the edge.
  task automatic step();
    exp_t e;
    exp_t h;
    @(negedge clk);
    check("out_valid", out_valid, sb.size() > 0);
    check("in_ready", in_ready, sb.size() < 2);
    if (out_valid && out_ready && sb.size() > 0) begin
      h = sb.pop_front();
      check("out_data", out_data, h.data);
      check("out_status", out_status, h.status);
    end
    last_accept = in_valid && in_ready;
    if (last_accept) begin
      e = decode(in_data);
      sb.push_back(e);
    end
    if (clr_cnt) begin
      exp_corr   = 0;
      exp_uncorr = 0;
    end else if (last_accept) begin
      if (e.status == 2'b01 && exp_corr < 3) exp_corr++;
      if (e.status[1] && exp_uncorr < 3)    exp_uncorr++;
    end
    @(posedge clk);
    #1;
    check("corr_cnt", corr_cnt, exp_corr);
    check("uncorr_cnt", uncorr_cnt, exp_uncorr);
  endtask

  task automatic send_one(input logic [6:0] f);
    in_valid = 1'b1;
    in_data  = f;
    step();
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    int tries;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    clr_cnt   = 1'b0;
    exp_corr  = 0;
    exp_uncorr = 0;

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_status", out_status, 0);
    check("rst_corr", corr_cnt, 0);
    check("rst_uncorr", uncorr_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", in_ready, 1);

    // Directed frames, each from cleared counters.
    send_one(7'b0111111);
    check("clean_corr", corr_cnt, 0);
    send_one(7'b0011101);
    check("corr_corr", corr_cnt, 1);
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    send_one(7'b0101101);
    check("tie_uncorr", uncorr_cnt, 1);
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    send_one(7'b1000000);
    check("pad_uncorr", uncorr_cnt, 1);
    send_one(7'b0000000);
    send_one(7'b0100010);
    send_one(7'b1011100);
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;

    // Backpressure: three back-to-back frames into a two-entry FIFO.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 7'b0111111; step();
    in_data   = 7'b0000001; step();
    in_data   = 7'b0100110; step();
    check("bp_held_ready", in_ready, 0);
    step();
    out_ready = 1'b1;
    step();
    check("bp_ready_after_pop", in_ready, 1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("bp_drained", sb.size(), 0);

    // Saturation at 3, then clear coinciding with an accept.
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    in_valid = 1'b1;
    in_data  = 7'b0011101;
    for (int i = 0; i < 5; i++) step();
    check("sat_corr", corr_cnt, 3);
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    check("clr_priority", corr_cnt, 0);
    in_valid = 1'b0;
    step(); step();

    // Sweep every frame value under random backpressure.
    for (int f = 0; f < 128; f++) begin
      in_valid = 1'b1;
      in_data  = 7'(f);
      tries = 0;
      do begin
        out_ready = 1'($urandom_range(0, 1));
        tries++;
        step();
      end while (!last_accept && tries < 64);
      check("sweep_accept", last_accept, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    check("sweep_drained", sb.size(), 0);

    // Reset mid-stream with a full FIFO.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 7'b0101101; step();
    in_data   = 7'b0011101; step();
    in_valid  = 1'b0;
    check("pre_rst_full", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    exp_corr   = 0;
    exp_uncorr = 0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_corr", corr_cnt, 0);
    check("mid_rst_uncorr", uncorr_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    out_ready = 1'b1;
    send_one(7'b0111111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
